// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters with
// hazard detection, issue accept/stall and sticky error flags.
module reg_scoreboard #(
  parameter int CNT_W       = 2,
  parameter int STALL_LIMIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic        issue_uses_rt,
  input  logic        issue_wr,
  input  logic [4:0]  issue_rd,
  input  logic        reg_wr,
  input  logic [4:0]  reg_wr_addr,
  output logic        issue_accept,
  output logic        stall_flag,
  output logic [31:0] busy_vec,
  output logic        stall_timeout,
  output logic        wb_underflow
);

  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [SW-1:0] SLIM = SW'(STALL_LIMIT);

  typedef enum logic {RUN, STALL} state_t;

  logic [CNT_W-1:0] cnt_q [32];
  state_t           state_q, state_d;
  logic [SW-1:0]    scnt_q, scnt_d;

  logic [CNT_W-1:0] rs_c, rt_c, rd_c, wb_c;
  logic             haz_rs, haz_rt, rd_full;
  logic             inc, dec, uflow;

  // Entry 0 is reset to zero and never written, so reads of r0 see 0.
  assign rs_c = cnt_q[issue_rs];
  assign rt_c = cnt_q[issue_rt];
  assign rd_c = cnt_q[issue_rd];
  assign wb_c = cnt_q[reg_wr_addr];

  // A last pending write retiring this cycle lands before the read.
  assign haz_rs = (rs_c != '0) &&
    !((rs_c == CNT_W'(1)) && reg_wr && (reg_wr_addr == issue_rs));
  assign haz_rt = issue_uses_rt && (rt_c != '0) &&
    !((rt_c == CNT_W'(1)) && reg_wr && (reg_wr_addr == issue_rt));
  assign rd_full = issue_wr && (issue_rd != '0) && (rd_c == CMAX) &&
    !(reg_wr && (reg_wr_addr == issue_rd));

  assign issue_accept = issue_valid && !haz_rs && !haz_rt && !rd_full;
  assign stall_flag   = issue_valid && !issue_accept;

  assign inc   = issue_accept && issue_wr && (issue_rd != '0);
  assign dec   = reg_wr && (reg_wr_addr != '0) && (wb_c != '0);
  assign uflow = reg_wr && (reg_wr_addr != '0) && (wb_c == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        case ({inc && (issue_rd == 5'(i)),
               dec && (reg_wr_addr == 5'(i))})
          2'b10:   cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          2'b01:   cnt_q[i] <= cnt_q[i] - CNT_W'(1);
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < 32; i++) busy_vec[i] = (cnt_q[i] != '0);
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    unique case (state_q)
      RUN: begin
        if (stall_flag) begin
          state_d = STALL;
          scnt_d  = SW'(1);
        end
      end
      STALL: begin
        if (!stall_flag) begin
          state_d = RUN;
          scnt_d  = '0;
        end else if (scnt_q != SLIM) begin
          scnt_d = scnt_q + SW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      scnt_q        <= '0;
      stall_timeout <= 1'b0;
      wb_underflow  <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      if (stall_flag && (scnt_d == SLIM)) stall_timeout <= 1'b1;
      if (uflow) wb_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hazards, saturation,
// underflow, stall timeout and asynchronous reset.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rs;
  logic [4:0]  issue_rt;
  logic        issue_uses_rt;
  logic        issue_wr;
  logic [4:0]  issue_rd;
  logic        reg_wr;
  logic [4:0]  reg_wr_addr;
  logic        issue_accept;
  logic        stall_flag;
  logic [31:0] busy_vec;
  logic        stall_timeout;
  logic        wb_underflow;

  int checks = 0;
  int errors = 0;

  reg_scoreboard #(.CNT_W(2), .STALL_LIMIT(15)) dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_rs      (issue_rs),
    .issue_rt      (issue_rt),
    .issue_uses_rt (issue_uses_rt),
    .issue_wr      (issue_wr),
    .issue_rd      (issue_rd),
    .reg_wr        (reg_wr),
    .reg_wr_addr   (reg_wr_addr),
    .issue_accept  (issue_accept),
    .stall_flag    (stall_flag),
    .busy_vec      (busy_vec),
    .stall_timeout (stall_timeout),
    .wb_underflow  (wb_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    issue_valid   = 1'b0;
    issue_rs      = '0;
    issue_rt      = '0;
    issue_uses_rt = 1'b0;
    issue_wr      = 1'b0;
    issue_rd      = '0;
    reg_wr        = 1'b0;
    reg_wr_addr   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic wr,
                       input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_rs    = rs;
    issue_wr    = wr;
    issue_rd    = rd;
  endtask

  task automatic retire(input logic [4:0] a);
    reg_wr      = 1'b1;
    reg_wr_addr = a;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #12;
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_tmo", 32'(stall_timeout), 32'h0);
    chk("rst_uflow", 32'(wb_underflow), 32'h0);
    chk("rst_acc", 32'(issue_accept), 32'h0);
    chk("rst_stall", 32'(stall_flag), 32'h0);
    #1 reset = 1'b1;
    step();

    // rd=5 then rs=5 hazard, cleared by same-cycle retire
    issue(5'd0, 1'b1, 5'd5);
    #1 chk("r5_acc", 32'(issue_accept), 32'h1);
    step();
    idle();
    issue(5'd5, 1'b0, 5'd0);
    #1 chk("r5_stall", 32'(stall_flag), 32'h1);
    chk("r5_acc0", 32'(issue_accept), 32'h0);
    chk("r5_busy", 32'(busy_vec[5]), 32'h1);
    retire(5'd5);
    #1 chk("r5_bypass", 32'(issue_accept), 32'h1);
    chk("r5_nostall", 32'(stall_flag), 32'h0);
    step();
    idle();
    #1 chk("r5_clear", 32'(busy_vec[5]), 32'h0);

    // register 0 is never tracked
    issue(5'd0, 1'b1, 5'd0);
    #1 chk("r0_wr_acc", 32'(issue_accept), 32'h1);
    step();
    idle();
    issue(5'd0, 1'b0, 5'd0);
    #1 chk("r0_rd_acc", 32'(issue_accept), 32'h1);
    step();
    idle();
    chk("r0_busy", busy_vec, 32'h0);

    // saturate r7 at 3 outstanding writes
    for (int i = 0; i < 3; i++) begin
      issue(5'd0, 1'b1, 5'd7);
      #1 chk("r7_fill", 32'(issue_accept), 32'h1);
      step();
    end
    idle();
    chk("r7_busy", busy_vec, 32'h0000_0080);
    issue(5'd0, 1'b1, 5'd7);
    #1 chk("r7_sat_stall", 32'(stall_flag), 32'h1);
    retire(5'd7);
    #1 chk("r7_sat_bypass", 32'(issue_accept), 32'h1);
    step();
    idle();
    issue(5'd0, 1'b1, 5'd7);
    #1 chk("r7_still_sat", 32'(stall_flag), 32'h1);
    idle();
    retire(5'd7);
    step();
    chk("r7_cnt2", 32'(busy_vec[7]), 32'h1);
    step();
    chk("r7_cnt1", 32'(busy_vec[7]), 32'h1);
    step();
    idle();
    chk("r7_cnt0", 32'(busy_vec[7]), 32'h0);
    chk("r7_no_uflow", 32'(wb_underflow), 32'h0);

    // writeback underflow on r9, then r0 writeback ignored
    retire(5'd9);
    step();
    idle();
    chk("uf_flag", 32'(wb_underflow), 32'h1);
    chk("uf_busy", busy_vec, 32'h0);
    retire(5'd0);
    step();
    idle();
    step();
    chk("uf_sticky", 32'(wb_underflow), 32'h1);

    // stall timeout on r4
    issue(5'd0, 1'b1, 5'd4);
    step();
    idle();
    issue(5'd4, 1'b0, 5'd0);
    for (int i = 0; i < 14; i++) step();
    chk("tmo_14", 32'(stall_timeout), 32'h0);
    step();
    chk("tmo_15", 32'(stall_timeout), 32'h1);
    retire(5'd4);
    #1 chk("tmo_acc", 32'(issue_accept), 32'h1);
    step();
    idle();
    chk("tmo_sticky", 32'(stall_timeout), 32'h1);
    chk("tmo_busy", busy_vec, 32'h0);
    issue(5'd0, 1'b0, 5'd0);
    #1 chk("tmo_run_acc", 32'(issue_accept), 32'h1);
    idle();

    // rt gating, then asynchronous reset mid-stall
    issue(5'd0, 1'b1, 5'd4);
    step();
    issue(5'd0, 1'b1, 5'd7);
    step();
    idle();
    chk("pre_rst_busy", busy_vec, 32'h0000_0090);
    issue(5'd0, 1'b0, 5'd0);
    issue_rt = 5'd7;
    #1 chk("rt_unused", 32'(issue_accept), 32'h1);
    issue_uses_rt = 1'b1;
    #1 chk("rt_used", 32'(stall_flag), 32'h1);
    step();
    step();
    chk("stalled_busy", busy_vec, 32'h0000_0090);
    chk("stalled_flag", 32'(stall_flag), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", busy_vec, 32'h0);
    chk("arst_stall", 32'(stall_flag), 32'h0);
    chk("arst_tmo", 32'(stall_timeout), 32'h0);
    chk("arst_uflow", 32'(wb_underflow), 32'h0);
    idle();
    step();
    #2 reset = 1'b1;
    step();
    issue(5'd4, 1'b1, 5'd7);
    #1 chk("post_rst_acc", 32'(issue_accept), 32'h1);
    step();
    idle();
    chk("post_rst_busy", busy_vec, 32'h0000_0080);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter CNT_W, default 2: width of the per-register pending-write counter; max outstanding writes per register = 2^CNT_W-1.
REQ-002 SHALL have parameter STALL_LIMIT, default 15: consecutive stall cycles after which stall_timeout sets.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 issue_valid  in  1  decode presents an instruction this cycle.
REQ-006 issue_rs  in  5  source register 1 address.
REQ-007 issue_rt  in  5  source register 2 address.
REQ-008 issue_uses_rt  in  1  instruction reads issue_rt.
REQ-009 issue_wr  in  1  instruction will write a destination.
REQ-010 issue_rd  in  5  destination register address.
REQ-011 reg_wr  in  1  writeback retires one pending write this cycle.
REQ-012 reg_wr_addr  in  5  writeback destination.
REQ-013 issue_accept  out  1  instruction accepted this cycle; combinational.
REQ-014 stall_flag  out  1  decode must hold; combinational.
REQ-015 busy_vec  out  32  bit i = register i has a nonzero pending count; registered.
REQ-016 stall_timeout  out  1  sticky error; registered.
REQ-017 wb_underflow  out  1  sticky error; registered.

Function
REQ-018 SHALL keep one CNT_W-bit pending counter per register 1..31; register 0 SHALL never be busy and SHALL never be counted.
REQ-019 A source is in hazard when its counter is nonzero, except when the counter = 1 and reg_wr=1 with reg_wr_addr equal to that source in the same cycle. That write lands before the next read, so there is no hazard.
REQ-020 rt SHALL be checked only when issue_uses_rt=1.
REQ-021 issue_accept SHALL be 1 iff issue_valid=1, there is no source hazard, and NOT (issue_wr=1, issue_rd!=0, and the rd counter is saturated with no same-cycle retire to rd).
REQ-022 stall_flag SHALL be 1 iff issue_valid=1 and issue_accept=0; both outputs SHALL be 0 when issue_valid=0.
REQ-023 On accept with issue_wr=1 and issue_rd!=0, the rd counter SHALL increment by 1 at the next posedge.
REQ-024 On reg_wr=1 with reg_wr_addr!=0, that counter SHALL decrement by 1 at the next posedge.
REQ-025 If the increment and decrement target the same register in one cycle, the counter SHALL be unchanged.
REQ-026 reg_wr=1 to a register whose counter is 0: counter stays 0; wb_underflow SHALL set at the next posedge.
REQ-027 reg_wr to register 0 SHALL be ignored with no error.
REQ-028 Counters SHALL never wrap; saturation is prevented by REQ-021.
REQ-029 FSM with two states. RUN: go to STALL when stall_flag=1. STALL: go to RUN when stall_flag=0. The stall counter increments each STALL cycle and clears on entry to RUN.
REQ-030 When the stall counter reaches STALL_LIMIT, stall_timeout SHALL set. The FSM stays in STALL, and the counter saturates at STALL_LIMIT.
REQ-031 busy_vec SHALL reflect counters after the posedge update, giving one-cycle latency from accept or retire.
REQ-032 Sticky errors SHALL clear only on reset.

Reset
REQ-033 While reset=0, regardless of clk: all counters 0, busy_vec=0, FSM=RUN, stall counter=0, stall_timeout=0, wb_underflow=0.
REQ-034 Reset asserted mid-stall SHALL immediately drop all pending state.
REQ-035 The first posedge after deassertion SHALL be able to accept an instruction.

Verification
REQ-036 Issue rd=5, then next cycle rs=5 with no writeback -> first cycle accept=1; second cycle stall_flag=1, busy_vec[5]=1; reg_wr to 5 -> accept=1 in that same cycle, busy_vec[5]=0 the following cycle.
REQ-037 Issue rd=0, then rs=0 -> both accepted; busy_vec stays 0.
REQ-038 Three issues to rd=7 with no retire (CNT_W=2) -> fourth rd=7 issue stalls; same fourth issue with reg_wr to 7 in that cycle -> accepted, counter stays 3.
REQ-039 reg_wr to 9 with counter 0 -> wb_underflow=1, busy_vec[9]=0; error persists until reset.
REQ-040 Hold a hazard on rs=4 for 15 cycles -> stall_timeout=1 on the 15th; then retire 4 -> accept, FSM RUN, stall_timeout still 1.
REQ-041 Assert reset while busy_vec=32'h0000_0090 and stalled -> busy_vec=0 and stall_flag=0 before the next clk edge.
